// File: rtl/axis_bram_sched.sv
// rtl/axis_bram_sched.sv - two-requester BRAM transfer scheduler driving a stream/BRAM adapter
module axis_bram_sched #(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int CNT_W              = BRAM_ADDR_LENGTH + 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic                        req0_rw,
  input  logic                        req1_rw,
  input  logic [BRAM_ADDR_LENGTH-1:0] req0_start,
  input  logic [BRAM_ADDR_LENGTH-1:0] req1_start,
  input  logic [BRAM_ADDR_LENGTH-1:0] req0_bound,
  input  logic [BRAM_ADDR_LENGTH-1:0] req1_bound,
  output logic [1:0]                  done,
  output logic [1:0]                  err,
  input  logic                        abort,
  output logic                        aborted,
  input  logic                        beat,
  output logic                        rw,
  output logic                        addr_reload,
  output logic                        xfer_active,
  output logic [BRAM_ADDR_LENGTH-1:0] bram_start_index,
  output logic [BRAM_ADDR_LENGTH-1:0] bram_bound_index,
  output logic                        owner
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] WORDS = CNT_W'(BRAM_WIDTH_IN_WORD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t                      state, state_next;
  logic                        prio;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            target;
  logic [1:0]                  cand;
  logic                        have_req;
  logic                        pick;
  logic                        sel_rw;
  logic [BRAM_ADDR_LENGTH-1:0] sel_start;
  logic [BRAM_ADDR_LENGTH-1:0] sel_bound;
  logic                        bad_cmd;
  logic [CNT_W-1:0]            span;
  logic                        final_beat;
  logic                        abort_hit;

  // Round-robin pick; a requester already being acknowledged this cycle is masked so it is not served twice
  always_comb begin
    cand      = req_valid & ~req_ready;
    have_req  = |cand;
    pick      = (cand == 2'b11) ? prio : cand[1];
    sel_rw    = pick ? req1_rw    : req0_rw;
    sel_start = pick ? req1_start : req0_start;
    sel_bound = pick ? req1_bound : req0_bound;
    bad_cmd   = sel_bound < sel_start;
    span      = CNT_W'(sel_bound) - CNT_W'(sel_start) + ONE;
    final_beat = (state == S_RUN) && beat && ((cnt + ONE) == target);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state; the final beat wins over a coincident abort
  always_comb begin
    state_next = state;
    abort_hit  = 1'b0;
    case (state)
      S_IDLE:   if (have_req && !bad_cmd) state_next = S_LOAD;
      S_LOAD:   begin
                  if (abort) begin state_next = S_DONE; abort_hit = 1'b1; end
                  else             state_next = S_SETTLE;
                end
      S_SETTLE: begin
                  if (abort) begin state_next = S_DONE; abort_hit = 1'b1; end
                  else             state_next = S_RUN;
                end
      S_RUN:    begin
                  if (final_beat)  state_next = S_DONE;
                  else if (abort) begin state_next = S_DONE; abort_hit = 1'b1; end
                end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    addr_reload = (state == S_LOAD);
    xfer_active = (state == S_RUN);
    done        = 2'b00;
    if (state == S_DONE) done[owner] = 1'b1;
  end

  // Command latching, handshake pulses, arbitration priority and beat counting
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_ready        <= 2'b00;
      err              <= 2'b00;
      rw               <= 1'b0;
      bram_start_index <= '0;
      bram_bound_index <= '0;
      owner            <= 1'b0;
      prio             <= 1'b0;
      target           <= '0;
      cnt              <= '0;
      aborted          <= 1'b0;
    end else begin
      req_ready <= 2'b00;
      err       <= 2'b00;
      if (state == S_IDLE && have_req) begin
        req_ready[pick] <= 1'b1;
        prio            <= ~pick;
        if (bad_cmd) begin
          err[pick] <= 1'b1;
        end else begin
          rw               <= sel_rw;
          bram_start_index <= sel_start;
          bram_bound_index <= sel_bound;
          owner            <= pick;
          target           <= span * WORDS;
        end
      end
      // Counter is held at zero outside RUN so it always enters RUN cleared
      if (state != S_RUN) cnt <= '0;
      else if (beat)      cnt <= cnt + ONE;
      aborted <= (state_next == S_DONE) && abort_hit;
    end
  end

endmodule
